// File: rtl/vedic_mult_pipe.sv
// Two-stage pipelined Vedic (Urdhva-Tiryagbhyam) multiplier, WIDTH x WIDTH -> 2*WIDTH, valid/ready on both sides.
// Define VEDIC_SIGNED_EN to add a signed_mode port for two's-complement operands; the default build is unsigned only.
module vedic_mult_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
`ifdef VEDIC_SIGNED_EN
  input  logic               signed_mode,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;
  localparam int LV = $clog2(H);

  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_width_check
    $error("vedic_mult_pipe: WIDTH must be a power of two and at least 4");
  end

  logic               en;
  logic               s1_v_reg;
  logic               s2_v_reg;
  logic [WIDTH-1:0]   s1_cp_reg [4];
  logic [WIDTH:0]     mid_sum;
  logic [PW-1:0]      mag_sum;
  logic [PW-1:0]      product_next;
  logic [PW-1:0]      product_reg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   cp [4];

  // The whole pipe advances together; a stalled output freezes every stage.
  assign en        = ~s2_v_reg | out_ready;
  assign in_ready  = en;
  assign out_valid = s2_v_reg;
  assign product   = product_reg;

`ifdef VEDIC_SIGNED_EN
  logic neg_a;
  logic neg_b;
  logic s1_sign_reg;

  assign neg_a = signed_mode & A[WIDTH-1];
  assign neg_b = signed_mode & B[WIDTH-1];
  // -2^(WIDTH-1) negates to itself, which read unsigned is exactly its magnitude.
  assign mag_a = neg_a ? -A : A;
  assign mag_b = neg_b ? -B : B;
`else
  assign mag_a = A;
  assign mag_b = B;
`endif

  // cp[0]=LL, cp[1]=HL (A high x B low), cp[2]=LH, cp[3]=HH; each is an H x H tree of 2x2 cells.
  for (genvar gi = 0; gi < 4; gi++) begin : g_cp
    logic [H-1:0] op_a;
    logic [H-1:0] op_b;

    assign op_a = (gi % 2 == 1) ? mag_a[WIDTH-1:H] : mag_a[H-1:0];
    assign op_b = (gi / 2 == 1) ? mag_b[WIDTH-1:H] : mag_b[H-1:0];

    for (genvar gl = 0; gl < LV; gl++) begin : lvl
      localparam int W = 2 << gl;
      localparam int C = H / W;
      logic [2*W-1:0] pp [C][C];

      for (genvar gr = 0; gr < C; gr++) begin : g_row
        for (genvar gc = 0; gc < C; gc++) begin : g_col
          if (gl == 0) begin : g_cell
            logic [1:0] x;
            logic [1:0] y;
            logic       t1;
            logic       t2;
            logic       t3;
            logic       c1;

            assign x  = op_a[2*gr +: 2];
            assign y  = op_b[2*gc +: 2];
            assign t1 = x[1] & y[0];
            assign t2 = x[0] & y[1];
            assign c1 = t1 & t2;
            assign t3 = x[1] & y[1];
            assign pp[gr][gc] = {t3 & c1, t3 ^ c1, t1 ^ t2, x[0] & y[0]};
          end else begin : g_node
            localparam int HW = W / 2;
            logic [2*W-1:0] ll;
            logic [2*W-1:0] lh;
            logic [2*W-1:0] hl;
            logic [2*W-1:0] hh;

            assign ll = {{W{1'b0}}, lvl[gl-1].pp[2*gr][2*gc]};
            assign hl = {{W{1'b0}}, lvl[gl-1].pp[2*gr+1][2*gc]};
            assign lh = {{W{1'b0}}, lvl[gl-1].pp[2*gr][2*gc+1]};
            assign hh = {{W{1'b0}}, lvl[gl-1].pp[2*gr+1][2*gc+1]};
            assign pp[gr][gc] = ll + ((lh + hl) << HW) + (hh << W);
          end
        end
      end
    end

    assign cp[gi] = lvl[LV-1].pp[0][0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_reg <= 1'b0;
      for (int i = 0; i < 4; i++) s1_cp_reg[i] <= '0;
`ifdef VEDIC_SIGNED_EN
      s1_sign_reg <= 1'b0;
`endif
    end else if (en) begin
      s1_v_reg <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < 4; i++) s1_cp_reg[i] <= cp[i];
`ifdef VEDIC_SIGNED_EN
        s1_sign_reg <= neg_a ^ neg_b;
`endif
      end
    end
  end

  assign mid_sum = {1'b0, s1_cp_reg[1]} + {1'b0, s1_cp_reg[2]};
  assign mag_sum = PW'(s1_cp_reg[0]) + (PW'(mid_sum) << H) + (PW'(s1_cp_reg[3]) << WIDTH);

`ifdef VEDIC_SIGNED_EN
  assign product_next = s1_sign_reg ? -mag_sum : mag_sum;
`else
  assign product_next = mag_sum;
`endif

  // product only loads on a real result, so it keeps its last value across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_reg    <= 1'b0;
      product_reg <= '0;
    end else if (en) begin
      s2_v_reg <= s1_v_reg;
      if (s1_v_reg) product_reg <= product_next;
    end
  end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Directed and random checks of vedic_mult_pipe at WIDTH=4 and WIDTH=8.
// Signed-mode vectors run only when VEDIC_SIGNED_EN is defined.
module tb_vedic_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        v4, r4, or4, ov4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  logic        v8, r8, or8, ov8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic        sm4, sm8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vedic_mult_pipe #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v4), .in_ready(r4), .A(a4), .B(b4),
`ifdef VEDIC_SIGNED_EN
    .signed_mode(sm4),
`endif
    .out_valid(ov4), .out_ready(or4), .product(p4)
  );

  vedic_mult_pipe #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v8), .in_ready(r8), .A(a8), .B(b8),
`ifdef VEDIC_SIGNED_EN
    .signed_mode(sm8),
`endif
    .out_valid(ov8), .out_ready(or8), .product(p8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    v4 = 1'b0; or4 = 1'b1; a4 = '0; b4 = '0; sm4 = 1'b0;
    v8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; sm8 = 1'b0;
    #2;
    checks++;
    if (ov4 !== 1'b0 || p4 !== 8'd0 || r4 !== 1'b1) begin
      errors++;
      $display("FAIL reset_w4: out_valid=%b product=%0d in_ready=%b, want 0 0 1", ov4, p4, r4);
    end
    checks++;
    if (ov8 !== 1'b0 || p8 !== 16'd0 || r8 !== 1'b1) begin
      errors++;
      $display("FAIL reset_w8: out_valid=%b product=%0d in_ready=%b, want 0 0 1", ov8, p8, r8);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0] ta [5] = '{4'd4, 4'd6, 4'd4, 4'd11, 4'd6};
    logic [3:0] tb [5] = '{4'd12, 4'd14, 4'd8, 4'd12, 4'd15};
    logic [7:0] te [5] = '{8'd48, 8'd84, 8'd32, 8'd132, 8'd90};
    or4 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 5) begin
        v4 = 1'b1; a4 = ta[c]; b4 = tb[c];
      end else begin
        v4 = 1'b0;
      end
      step();
      checks++;
      if (c == 0) begin
        if (ov4 !== 1'b0) begin
          errors++;
          $display("FAIL b2b_latency: out_valid=%b one cycle after accept, want 0", ov4);
        end
      end else begin
        $display("b2b: %0d x %0d -> %0d", ta[c-1], tb[c-1], p4);
        if (ov4 !== 1'b1 || p4 !== te[c-1]) begin
          errors++;
          $display("FAIL b2b[%0d]: out_valid=%b product=%0d, want 1 %0d", c - 1, ov4, p4, te[c-1]);
        end
      end
    end
    step();
    checks++;
    if (ov4 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: out_valid=%b after last product, want 0", ov4);
    end
  endtask

  task automatic test_width8();
    logic [7:0]  ta [3] = '{8'h00, 8'hFF, 8'h80};
    logic [7:0]  tb [3] = '{8'hA5, 8'hFF, 8'h02};
    logic [15:0] te [3] = '{16'd0, 16'hFE01, 16'd256};
    or8 = 1'b1; sm8 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c < 3) begin
        v8 = 1'b1; a8 = ta[c]; b8 = tb[c];
      end else begin
        v8 = 1'b0;
      end
      step();
      if (c > 0) begin
        checks++;
        $display("w8: %02h x %02h -> %04h", ta[c-1], tb[c-1], p8);
        if (ov8 !== 1'b1 || p8 !== te[c-1]) begin
          errors++;
          $display("FAIL w8[%0d]: out_valid=%b product=%04h, want 1 %04h", c - 1, ov8, p8, te[c-1]);
        end
      end
    end
    step();
  endtask

  task automatic test_stall();
    or4 = 1'b1;
    v4 = 1'b1; a4 = 4'd3; b4 = 4'd5;
    step();
    a4 = 4'd7; b4 = 4'd9;
    step();
    v4 = 1'b0; or4 = 1'b0;
    #1;
    checks++;
    if (r4 !== 1'b0) begin
      errors++;
      $display("FAIL stall_ready: in_ready=%b with full pipe and out_ready=0, want 0", r4);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (ov4 !== 1'b1 || p4 !== 8'd15 || r4 !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: out_valid=%b product=%0d in_ready=%b, want 1 15 0", i, ov4, p4, r4);
      end
    end
    or4 = 1'b1;
    #1;
    checks++;
    $display("stall: delivered %0d", p4);
    if (ov4 !== 1'b1 || p4 !== 8'd15 || r4 !== 1'b1) begin
      errors++;
      $display("FAIL stall_release1: out_valid=%b product=%0d in_ready=%b, want 1 15 1", ov4, p4, r4);
    end
    step();
    checks++;
    $display("stall: delivered %0d", p4);
    if (ov4 !== 1'b1 || p4 !== 8'd63) begin
      errors++;
      $display("FAIL stall_release2: out_valid=%b product=%0d, want 1 63", ov4, p4);
    end
    step();
    checks++;
    if (ov4 !== 1'b0) begin
      errors++;
      $display("FAIL stall_dup: out_valid=%b after both delivered, want 0", ov4);
    end
  endtask

  task automatic test_reset_midop();
    or4 = 1'b1;
    v4 = 1'b1; a4 = 4'd9; b4 = 4'd9;
    step();
    v4 = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov4 !== 1'b0 || p4 !== 8'd0 || r4 !== 1'b1) begin
      errors++;
      $display("FAIL midop_reset: out_valid=%b product=%0d in_ready=%b, want 0 0 1", ov4, p4, r4);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (ov4 !== 1'b0 || p4 !== 8'd0) begin
        errors++;
        $display("FAIL midop_release[%0d]: out_valid=%b product=%0d, want 0 0", i, ov4, p4);
      end
    end
  endtask

`ifdef VEDIC_SIGNED_EN
  task automatic test_signed();
    logic [7:0]  ta [4] = '{8'hF8, 8'h80, 8'h7F, 8'hF8};
    logic [7:0]  tb [4] = '{8'h07, 8'h80, 8'hFF, 8'h07};
    logic        ts [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] te [4] = '{16'hFFC8, 16'h4000, 16'hFF81, 16'd1736};
    or8 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c < 4) begin
        v8 = 1'b1; a8 = ta[c]; b8 = tb[c]; sm8 = ts[c];
      end else begin
        v8 = 1'b0; sm8 = 1'b0;
      end
      step();
      if (c > 0) begin
        checks++;
        $display("signed: %02h x %02h mode=%b -> %04h", ta[c-1], tb[c-1], ts[c-1], p8);
        if (ov8 !== 1'b1 || p8 !== te[c-1]) begin
          errors++;
          $display("FAIL signed[%0d]: out_valid=%b product=%04h, want 1 %04h", c - 1, ov8, p8, te[c-1]);
        end
      end
    end
    step();
  endtask
`endif

  task automatic test_random();
    logic [15:0] q [$];
    logic [15:0] exp_p;
    logic [15:0] prev_p = '0;
    logic        prev_stall = 1'b0;
    logic        hold = 1'b0;
    logic        acc, dlv;
    int          sent = 0;
    int          cyc = 0;
    v8 = 1'b0; or8 = 1'b1; sm8 = 1'b0;
    while ((sent < 10000 || q.size() != 0) && cyc < 80000) begin
      if (!hold) begin
        v8 = (sent < 10000) && ($urandom_range(0, 3) != 0);
        a8 = 8'($urandom);
        b8 = 8'($urandom);
      end
      or8 = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (r8 !== (~ov8 | or8)) begin
        errors++;
        $display("FAIL rnd_ready cyc=%0d: in_ready=%b, want %b", cyc, r8, ~ov8 | or8);
      end
      if (prev_stall) begin
        checks++;
        if (ov8 !== 1'b1 || p8 !== prev_p) begin
          errors++;
          $display("FAIL rnd_hold cyc=%0d: out_valid=%b product=%04h, want 1 %04h", cyc, ov8, p8, prev_p);
        end
      end
      acc = v8 & r8;
      dlv = ov8 & or8;
      if (dlv) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra cyc=%0d: product=%04h delivered with nothing outstanding, want none", cyc, p8);
        end else begin
          exp_p = q.pop_front();
          if (p8 !== exp_p) begin
            errors++;
            $display("FAIL rnd_value cyc=%0d: product=%04h, want %04h", cyc, p8, exp_p);
          end
        end
      end
      if (acc) begin
        q.push_back(16'(a8) * 16'(b8));
        sent++;
      end
      prev_stall = ov8 & ~or8;
      prev_p     = p8;
      hold       = v8 & ~acc;
      step();
      cyc++;
    end
    v8 = 1'b0;
    checks++;
    $display("random: %0d ops in %0d cycles, %0d outstanding", sent, cyc, q.size());
    if (sent != 10000 || q.size() != 0) begin
      errors++;
      $display("FAIL rnd_timeout: sent=%0d outstanding=%0d, want 10000 0", sent, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_width8();
    test_stall();
    test_reset_midop();
`ifdef VEDIC_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
